// File: rtl/mips_bus_pkg.sv
// Shared bus definitions for the MIPS data-side interconnect.
package mips_bus_pkg;

  // Router transaction states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Target select encodings.
  localparam logic SEL_MEM = 1'b0;
  localparam logic SEL_IO  = 1'b1;

  // Addresses at or above this value belong to the I/O block.
  localparam logic [31:0] SPLIT_ADDR_DEFAULT = 32'hFFFF_0000;

endpackage

// File: rtl/watchdog_counter.sv
// Saturating cycle counter that flags when TIMEOUT-1 cycles have elapsed since clear.
module watchdog_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over count; saturate so expiry stays asserted once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_router32.sv
// Single-outstanding-request router from the CPU data port to memory (t0) or I/O (t1).
module mem_router32
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] SPLIT_ADDR = SPLIT_ADDR_DEFAULT,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_wdata_o,
  output logic        out_we_o,
  output logic        t0_valid_o,
  output logic        t1_valid_o,
  input  logic        t0_ready_i,
  input  logic        t1_ready_i,
  input  logic        t0_resp_valid_i,
  input  logic        t1_resp_valid_i,
  input  logic [31:0] t0_rdata_i,
  input  logic [31:0] t1_rdata_i
);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        misaligned;
  logic        expired;
  logic        sel_ready;
  logic        sel_resp;
  logic [31:0] sel_rdata;

  assign accept     = (state_q == StIdle) && req_valid_i;
  assign misaligned = (req_addr_i[1:0] != 2'b00);

  // Only the selected target is observed; the other one's strobes are ignored.
  assign sel_ready = (sel_q == SEL_IO) ? t1_ready_i      : t0_ready_i;
  assign sel_resp  = (sel_q == SEL_IO) ? t1_resp_valid_i : t0_resp_valid_i;
  assign sel_rdata = (sel_q == SEL_IO) ? t1_rdata_i      : t0_rdata_i;

  watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (accept),
    .en_i      ((state_q == StIssue) || (state_q == StWait)),
    .expired_o (expired)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a completing event takes priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = misaligned ? StResp : StIssue;
      StIssue: begin
        if (sel_ready) begin
          state_d = StWait;
        end else if (expired) begin
          state_d = StResp;
        end
      end
      StWait:  if (sel_resp || expired) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    req_ready_o  = (state_q == StIdle);
    t0_valid_o   = (state_q == StIssue) && (sel_q == SEL_MEM);
    t1_valid_o   = (state_q == StIssue) && (sel_q == SEL_IO);
    resp_valid_o = (state_q == StResp);
  end

  // Request latch and response holding-register next values.
  always_comb begin
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          sel_d   = (req_addr_i >= SPLIT_ADDR);
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          we_d    = req_we_i;
          rdata_d = '0;
          err_d   = misaligned;
        end
      end
      StIssue: begin
        if (!sel_ready && expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      StWait: begin
        if (sel_resp) begin
          rdata_d = we_q ? 32'h0 : sel_rdata;
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q   <= SEL_MEM;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign out_addr_o   = addr_q;
  assign out_wdata_o  = wdata_q;
  assign out_we_o     = we_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: doc/mem_router32.md
# mem_router32

Single-request 32-bit bus router between the CPU data-memory port and two downstream targets: data memory (target 0) and the memory-mapped I/O block (target 1). It accepts one load/store request, decodes the address, steers the request to the selected target, waits for that target's response, and returns read data or an error to the CPU. Only one transaction is outstanding at a time. A watchdog converts a stalled target into an error response.

## Interface
- SPLIT_ADDR, 32'hFFFF_0000, addresses >= this value route to target 1; all others route to target 0
- TIMEOUT, 16, cycles allowed in ISSUE+WAIT before an error response; must be >= 2
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req_valid  in  1  CPU request present
- req_ready  out  1  router can accept a request; high only in IDLE
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_we  in  1  1 = store, 0 = load
- resp_valid  out  1  one-cycle response strobe; no back-pressure
- resp_rdata  out  32  load data; 0 on stores and errors
- resp_err  out  1  misaligned address or timeout; valid with resp_valid
- out_addr, out_wdata  out  32 each  latched request, shared by both targets
- out_we  out  1  latched req_we
- t0_valid, t1_valid  out  1 each  request to target; at most one high
- t0_ready, t1_ready  in  1 each  target accepts request
- t0_resp_valid, t1_resp_valid  in  1 each  target completion strobe
- t0_rdata, t1_rdata  in  32 each  target read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. If req_valid is high, latch addr/wdata/we, compute sel = (req_addr >= SPLIT_ADDR) as an unsigned compare, clear the watchdog, and clear the err and rdata holding registers.
  - If req_addr[1:0] != 0, go to RESP with err=1. No target is accessed.
  - Otherwise, go to ISSUE.
- ISSUE: drive t<sel>_valid=1. The other target's valid stays 0. The request stays stable until t<sel>_ready=1, then go to WAIT.
- WAIT: all target valids are 0. On t<sel>_resp_valid=1, capture t<sel>_rdata (forced to 0 if out_we=1) and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, with resp_rdata and resp_err from the holding registers. Next state is IDLE.
- Responses from the non-selected target are ignored in every state. Target responses are ignored in IDLE, ISSUE and RESP.
- Watchdog: counts each cycle spent in ISSUE or WAIT.
  - When the count reaches TIMEOUT-1 with no completing event in that cycle, go to RESP with err=1 and rdata=0.
  - If a completing event (ready in ISSUE, resp_valid in WAIT) occurs in the same cycle as the timeout, the completing event wins.
- Reset, including mid-transaction: state returns to IDLE, all registers clear, and the outstanding target transaction is abandoned. A late target response after reset is ignored.

## Timing
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, t0_valid=t1_valid=0, out_addr=out_wdata=0, out_we=0. req_ready=1, because it is decoded from state=IDLE.
- req_ready, t*_valid and resp_valid decode combinationally from the state register. All data outputs come from registers.
- Request handshake in cycle N:
  - t<sel>_valid is high from N+1.
  - With the target ready in N+1 and responding in N+2, resp_valid is high in N+3.
  - Minimum latency is 3 cycles from handshake to response.
- Misaligned request in cycle N: resp_valid=1 with err=1 in N+1.
- Timeout with a target that never readies: ISSUE is entered at N+1 and resp_valid=1 with err=1 at N+1+TIMEOUT.
- Next request can be accepted in the cycle after RESP, so maximum throughput is one request per 4 cycles.

## Structure
- Shared package mips_bus_pkg holds:
  - the state typedef (IDLE/ISSUE/WAIT/RESP);
  - SEL_MEM=1'b0 and SEL_IO=1'b1;
  - the default SPLIT_ADDR constant, shared with the address-map decoder and the I/O block.
- One sub-module, watchdog_counter, parameterised by TIMEOUT, with inputs clr and en and output expired. Counter width is $clog2(TIMEOUT).
- The read-data select is a plain 2:1 mux on sel; it needs no sub-module.

## Test plan
- Load 0x0000_0100: t0 ready in the first ISSUE cycle and t0_resp_valid one cycle later with 0xDEAD_BEEF. Required: resp_valid in handshake+3 with rdata 0xDEAD_BEEF, err=0; t1_valid never high.
- Store 0xFFFF_0004 with wdata 0x1234_5678. Required: t1_valid with out_we=1 and out_wdata 0x1234_5678, then resp rdata=0, err=0; t0_valid never high.
- Misaligned load 0x0000_0102. Required: resp_valid with err=1 in handshake+1; neither t*_valid ever asserted.
- TIMEOUT=16, t0 never ready. Required: resp_valid with err=1 and rdata=0 exactly 17 cycles after handshake; then req_ready=1. Repeat with t0_ready arriving on the expiry cycle: normal completion, err=0.
- Spurious t0_resp_valid pulsed during a t1 transaction, and during IDLE. Required: no effect; the t1 rdata is returned.
- rst_n asserted while in WAIT, then t0_resp_valid pulsed after release. Required: all outputs at reset values immediately, state IDLE, and no resp_valid is generated.
